// File: rtl/rvfi_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rvfi_trace_pkg
//  Description : Shared definitions for the RVFI trace transmitter: frame
//                geometry, record field layout, record packing helper and
//                the transmit FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rvfi_trace_pkg;

  localparam int         FRAME_BYTES       = 19;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Record layout, LSB first. The order matches the on-wire byte order of
  // bytes 1..18, so the frame can be emitted by shifting the record right.
  localparam int REC_W     = 144;
  localparam int PC_LSB    = 0;
  localparam int INSN_LSB  = 32;
  localparam int WDATA_LSB = 64;
  localparam int MADDR_LSB = 96;
  localparam int MASKS_LSB = 128;
  localparam int FLAGS_LSB = 136;

  typedef logic [REC_W-1:0] rvfi_record_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  function automatic rvfi_record_t pack_record(
    input logic        trap,
    input logic        intr,
    input logic        halt,
    input logic [4:0]  rd_addr,
    input logic [3:0]  mem_wmask,
    input logic [3:0]  mem_rmask,
    input logic [31:0] mem_addr,
    input logic [31:0] rd_wdata,
    input logic [31:0] insn,
    input logic [31:0] pc_rdata
  );
    rvfi_record_t rec;
    rec                    = '0;
    rec[FLAGS_LSB +: 8]    = {trap, intr, halt, rd_addr};
    rec[MASKS_LSB +: 8]    = {mem_wmask, mem_rmask};
    rec[MADDR_LSB +: 32]   = mem_addr;
    rec[WDATA_LSB +: 32]   = rd_wdata;
    rec[INSN_LSB +: 32]    = insn;
    rec[PC_LSB +: 32]      = pc_rdata;
    return rec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rvfi_trace_fifo
//  Description : Synchronous FIFO with registered full/empty flags derived
//                from pointers one bit wider than the slot address.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst_n (async, active-low)
//                push/push_data - write request, ignored when full
//                pop            - read request, ignored when empty
//                pop_data       - head entry (valid while !empty)
//                full/empty     - occupancy flags
// ============================================================================
module rvfi_trace_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int                c_ADDR_W  = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0] c_PTR_ONE = {{c_ADDR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [c_ADDR_W:0] r_wr_ptr;
  logic [c_ADDR_W:0] r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  // Same slot, different lap bit => full; identical pointers => empty.
  assign full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                 (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  // Full is taken from registered state, so a same-cycle pop never makes
  // room for a push.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/rvfi_trace_tx.sv
`default_nettype none
// ============================================================================
//  Module      : rvfi_trace_tx
//  Description : Captures retired-instruction RVFI records into a FIFO and
//                serialises each one as a 19-byte frame on a byte-wide
//                valid/ready stream. Records arriving while the FIFO is full
//                are dropped and counted instead of stalling the core.
//  Revision    : 1.0 - initial release
//  Ports       : clk, reset (async, active-low)
//                enable          - capture enable
//                rvfi_*          - RVFI record inputs, rvfi_valid strobe
//                tx_data/tx_valid/tx_ready - outgoing byte stream
//                busy            - frame in progress or records queued
//                overflow        - sticky record-loss flag
//                clear_overflow  - synchronous clear of overflow/drop_count
//                drop_count      - saturating count of dropped records
// ============================================================================
module rvfi_trace_tx
  import rvfi_trace_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             rvfi_valid,
  input  logic             rvfi_trap,
  input  logic             rvfi_halt,
  input  logic             rvfi_intr,
  input  logic [31:0]      rvfi_insn,
  input  logic [31:0]      rvfi_pc_rdata,
  input  logic [4:0]       rvfi_rd_addr,
  input  logic [31:0]      rvfi_rd_wdata,
  input  logic [31:0]      rvfi_mem_addr,
  input  logic [3:0]       rvfi_mem_rmask,
  input  logic [3:0]       rvfi_mem_wmask,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             overflow,
  input  logic             clear_overflow,
  output logic [CNT_W-1:0] drop_count
);

  localparam logic [4:0] c_LAST_IDX = 5'(FRAME_BYTES - 1);

  rvfi_record_t     w_record;
  rvfi_record_t     w_head;
  rvfi_record_t     r_frame;
  rvfi_record_t     w_frame_nxt;
  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [4:0]       r_idx;
  logic [4:0]       w_idx_nxt;
  logic             w_capture;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_count;

  assign w_record = pack_record(rvfi_trap, rvfi_intr, rvfi_halt, rvfi_rd_addr,
                                rvfi_mem_wmask, rvfi_mem_rmask, rvfi_mem_addr,
                                rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata);

  assign w_capture = enable & rvfi_valid;
  assign w_push    = w_capture & ~w_full;
  assign w_drop    = w_capture & w_full;

  rvfi_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (w_push),
    .push_data (w_record),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  // --------------------------------------------------------------------------
  // Transmit FSM. r_frame acts as a shift register: byte 1 sits in [7:0]
  // right after the load, and each accepted byte from byte 1 onward shifts
  // the next one down. Byte 0 is the constant sync byte, so no shift on it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_frame_nxt = r_frame;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_frame_nxt = w_head;
          w_idx_nxt   = '0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (r_idx == c_LAST_IDX) begin
            // Reload straight from the FIFO so consecutive frames have no gap.
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_frame_nxt = w_head;
              w_idx_nxt   = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + 5'd1;
            if (r_idx != '0) w_frame_nxt = r_frame >> 8;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign tx_valid = (r_state == ST_SEND);
  assign tx_data  = tx_valid ? ((r_idx == '0) ? SYNC_BYTE : r_frame[7:0]) : 8'h00;
  assign busy     = (r_state == ST_SEND) | ~w_empty;

  // --------------------------------------------------------------------------
  // Loss reporting. A drop in the same cycle as a clear wins, so the loss
  // that triggered nothing yet is still visible afterwards.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear_overflow) begin
      r_overflow   <= w_drop;
      r_drop_count <= w_drop ? CNT_W'(1) : '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_trace_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvfi_trace_tx
//  Description : Self-checking bench for rvfi_trace_tx. Expected frame bytes
//                are queued when a record is driven and compared as the DUT
//                hands bytes over the stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_trace_tx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] wdata;
    logic [31:0] maddr;
    logic [4:0]  rd;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic        trap;
    logic        intr;
    logic        halt;
  } rec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             rvfi_valid;
  logic             rvfi_trap;
  logic             rvfi_halt;
  logic             rvfi_intr;
  logic [31:0]      rvfi_insn;
  logic [31:0]      rvfi_pc_rdata;
  logic [4:0]       rvfi_rd_addr;
  logic [31:0]      rvfi_rd_wdata;
  logic [31:0]      rvfi_mem_addr;
  logic [3:0]       rvfi_mem_rmask;
  logic [3:0]       rvfi_mem_wmask;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             overflow;
  logic             clear_overflow;
  logic [CNT_W-1:0] drop_count;

  always #5 clk = ~clk;

  rvfi_trace_tx #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_BYTE  (8'hA5),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .rvfi_valid     (rvfi_valid),
    .rvfi_trap      (rvfi_trap),
    .rvfi_halt      (rvfi_halt),
    .rvfi_intr      (rvfi_intr),
    .rvfi_insn      (rvfi_insn),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_mem_addr  (rvfi_mem_addr),
    .rvfi_mem_rmask (rvfi_mem_rmask),
    .rvfi_mem_wmask (rvfi_mem_wmask),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb_q [$];

  // Written only by the monitor; the stimulus reads snapshots of them.
  int         acc_cnt      = 0;
  int         valid_cycles = 0;
  int         valid_runs   = 0;
  logic       prev_stall   = 1'b0;
  logic       prev_valid   = 1'b0;
  logic [7:0] prev_data    = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stream monitor, sampling on the falling edge.
  always @(negedge clk) begin
    logic [7:0] exp_byte;
    if (reset) begin
      if (tx_valid) valid_cycles++;
      if (tx_valid && !prev_valid) valid_runs++;
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (sb_q.size() == 0) begin
          check("extra_byte", 32'(tx_data), 32'h100);
        end else begin
          exp_byte = sb_q.pop_front();
          check("frame_byte", 32'(tx_data), 32'(exp_byte));
        end
        acc_cnt++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_valid = tx_valid;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end
  end

  function automatic rec_t mk_rec(input logic [31:0] pc, input logic [31:0] insn,
                                  input logic [4:0] rd, input logic [31:0] wdata);
    rec_t r;
    r       = '0;
    r.pc    = pc;
    r.insn  = insn;
    r.rd    = rd;
    r.wdata = wdata;
    return r;
  endfunction

  function automatic rec_t rnd_rec(input logic [31:0] pc);
    rec_t r;
    r.pc    = pc;
    r.insn  = $urandom;
    r.wdata = $urandom;
    r.maddr = $urandom;
    r.rd    = 5'($urandom_range(0, 31));
    r.rmask = 4'($urandom_range(0, 15));
    r.wmask = 4'($urandom_range(0, 15));
    r.trap  = 1'($urandom_range(0, 1));
    r.intr  = 1'($urandom_range(0, 1));
    r.halt  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Reference frame built field by field from the record.
  task automatic expect_frame(input rec_t r);
    sb_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) sb_q.push_back(r.pc[8*i +: 8]);
    for (int i = 0; i < 4; i++) sb_q.push_back(r.insn[8*i +: 8]);
    for (int i = 0; i < 4; i++) sb_q.push_back(r.wdata[8*i +: 8]);
    for (int i = 0; i < 4; i++) sb_q.push_back(r.maddr[8*i +: 8]);
    sb_q.push_back({r.wmask, r.rmask});
    sb_q.push_back({r.trap, r.intr, r.halt, r.rd});
  endtask

  // Called one time unit after a rising edge; presents the record for one cycle.
  task automatic drive_rec(input rec_t r, input logic en);
    enable         = en;
    rvfi_valid     = 1'b1;
    rvfi_pc_rdata  = r.pc;
    rvfi_insn      = r.insn;
    rvfi_rd_wdata  = r.wdata;
    rvfi_mem_addr  = r.maddr;
    rvfi_rd_addr   = r.rd;
    rvfi_mem_rmask = r.rmask;
    rvfi_mem_wmask = r.wmask;
    rvfi_trap      = r.trap;
    rvfi_intr      = r.intr;
    rvfi_halt      = r.halt;
    @(posedge clk); #1;
    rvfi_valid     = 1'b0;
    enable         = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_bytes_left"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r1;
    rec_t recs [7];
    int   base_v;
    int   base_r;
    int   base_a;
    int   n;

    reset          = 1'b0;
    enable         = 1'b0;
    rvfi_valid     = 1'b0;
    rvfi_trap      = 1'b0;
    rvfi_halt      = 1'b0;
    rvfi_intr      = 1'b0;
    rvfi_insn      = '0;
    rvfi_pc_rdata  = '0;
    rvfi_rd_addr   = '0;
    rvfi_rd_wdata  = '0;
    rvfi_mem_addr  = '0;
    rvfi_mem_rmask = '0;
    rvfi_mem_wmask = '0;
    tx_ready       = 1'b1;
    clear_overflow = 1'b0;

    #12;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    @(posedge clk); #1;
    reset  = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;

    // Single record: A5 00 01 00 00 93 00 A0 00 0A 00*8 01.
    r1     = mk_rec(32'h0000_0100, 32'h00A0_0093, 5'd1, 32'h0000_000A);
    base_v = valid_cycles;
    base_r = valid_runs;
    expect_frame(r1);
    drive_rec(r1, 1'b1);
    wait_drain("single", 60);
    check("single_valid_cycles", 32'(valid_cycles - base_v), 32'd19);
    check("single_valid_runs", 32'(valid_runs - base_r), 32'd1);

    // Backpressure: ready low when byte 0 appears, then alternating.
    tx_ready = 1'b0;
    base_v   = valid_cycles;
    expect_frame(r1);
    drive_rec(r1, 1'b1);
    for (int i = 0; i < 45; i++) begin
      tx_ready = ~tx_ready;
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_drain("bp", 60);
    check("bp_valid_cycles", 32'(valid_cycles - base_v), 32'd38);

    // Back-to-back: three records on consecutive cycles, one unbroken burst.
    base_v = valid_cycles;
    base_r = valid_runs;
    for (int i = 0; i < 3; i++) begin
      recs[i] = rnd_rec(32'h1000 + 32'(4 * i));
      expect_frame(recs[i]);
    end
    for (int i = 0; i < 3; i++) drive_rec(recs[i], 1'b1);
    wait_drain("b2b", 120);
    check("b2b_valid_cycles", 32'(valid_cycles - base_v), 32'd57);
    check("b2b_valid_runs", 32'(valid_runs - base_r), 32'd1);

    // A record with enable low is neither queued nor counted.
    drive_rec(rnd_rec(32'hDEAD_0000), 1'b0);
    wait_cycles(3);
    check("disabled_busy", 32'(busy), 32'd0);

    // Overflow: with the sink stalled, record 1 moves into the frame register
    // and records 2-5 fill the FIFO, so records 6 and 7 are dropped.
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      recs[i] = rnd_rec(32'h2000 + 32'(4 * i));
      if (i < 5) expect_frame(recs[i]);
    end
    for (int i = 0; i < 7; i++) drive_rec(recs[i], 1'b1);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop_count", 32'(drop_count), 32'd2);
    check("ovf_busy", 32'(busy), 32'd1);
    drive_rec(rnd_rec(32'h2100), 1'b0);
    check("ovf_disabled_not_counted", 32'(drop_count), 32'd2);
    tx_ready = 1'b1;
    wait_drain("ovf", 200);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Clear alone, then clear coinciding with a drop.
    clear_overflow = 1'b1;
    @(posedge clk); #1;
    clear_overflow = 1'b0;
    check("clr_flag", 32'(overflow), 32'd0);
    check("clr_drop_count", 32'(drop_count), 32'd0);
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      recs[i] = rnd_rec(32'h3000 + 32'(4 * i));
      if (i < 5) expect_frame(recs[i]);
    end
    for (int i = 0; i < 5; i++) drive_rec(recs[i], 1'b1);
    check("clr_no_drop_yet", 32'(drop_count), 32'd0);
    clear_overflow = 1'b1;
    drive_rec(recs[5], 1'b1);
    clear_overflow = 1'b0;
    check("clr_drop_flag", 32'(overflow), 32'd1);
    check("clr_drop_count1", 32'(drop_count), 32'd1);
    tx_ready = 1'b1;
    wait_drain("clr", 200);

    // Reset mid-frame after byte 7, with a second record still queued.
    recs[0] = rnd_rec(32'h4000);
    recs[1] = rnd_rec(32'h4004);
    expect_frame(recs[0]);
    base_a = acc_cnt;
    drive_rec(recs[0], 1'b1);
    drive_rec(recs[1], 1'b1);
    n = 0;
    while ((acc_cnt - base_a) < 8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_rst_reached_byte7", 32'(acc_cnt - base_a), 32'd8);
    check("mid_rst_valid_before", 32'(tx_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_cycles(2);
    check("post_rst_flushed", 32'(busy), 32'd0);
    recs[2] = rnd_rec(32'h5000);
    base_v  = valid_cycles;
    expect_frame(recs[2]);
    drive_rec(recs[2], 1'b1);
    wait_drain("post_rst", 60);
    check("post_rst_valid_cycles", 32'(valid_cycles - base_v), 32'd19);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
